// File: rtl/nibble_pair_packer.sv
// Assembles a valid/ready nibble stream into packed bytes {lo, hi}, padding odd packets.
// A single output register absorbs downstream backpressure while the next lo nibble is collected.
module nibble_pair_packer #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0,
    parameter int         COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_nibble,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic [COUNT_W-1:0] byte_count,
    output logic               ERROR
);

    typedef enum logic [1:0] {LO_WAIT, HI_WAIT, PAD} state_t;

    state_t     state;
    logic [3:0] lo_hold;
    logic       slot_free;
    logic       in_xfer;
    logic       out_xfer;

    assign slot_free = !out_valid || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // A lo nibble only fills lo_hold, so it is accepted even while the output is blocked.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            LO_WAIT: in_ready = 1'b1;
            HI_WAIT: in_ready = slot_free;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LO_WAIT;
            lo_hold    <= 4'h0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            out_last   <= 1'b0;
            byte_count <= '0;
            ERROR      <= 1'b0;
        end else begin
            // A load below overrides this clear, keeping full throughput.
            if (out_xfer) begin
                out_valid  <= 1'b0;
                byte_count <= byte_count + 1'b1;
            end
            case (state)
                LO_WAIT: begin
                    if (in_xfer) begin
                        lo_hold <= in_nibble;
                        state   <= in_last ? PAD : HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    if (in_xfer) begin
                        out_byte  <= {lo_hold, in_nibble};
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        state     <= LO_WAIT;
                    end
                end
                PAD: begin
                    if (slot_free) begin
                        out_byte  <= {lo_hold, PAD_NIBBLE};
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                        ERROR     <= 1'b1;
                        state     <= LO_WAIT;
                    end
                end
                default: state <= LO_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_pair_packer.sv
// Scoreboard bench: a 16-bit and a 4-bit counter instance share one stimulus stream.
module tb_nibble_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [3:0]  in_nibble;
    logic        in_ready, out_valid, out_last, err;
    logic [7:0]  out_byte;
    logic [15:0] cnt16;
    logic        in_ready4, out_valid4, out_last4, err4;
    logic [7:0]  out_byte4;
    logic [3:0]  cnt4;

    int ntests = 0;
    int nfail  = 0;
    int mdl_cnt = 0;
    int cyc = 0;
    int prev_x = -1;
    bit b2b = 0;
    bit have_lo = 0;
    logic [3:0] lo_m;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    nibble_pair_packer #(.PAD_NIBBLE(4'h0), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_nibble(in_nibble), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .byte_count(cnt16), .ERROR(err)
    );

    nibble_pair_packer #(.PAD_NIBBLE(4'h0), .COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_nibble(in_nibble), .in_last(in_last), .out_valid(out_valid4),
        .out_ready(out_ready), .out_byte(out_byte4), .out_last(out_last4),
        .byte_count(cnt4), .ERROR(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs sampled on the falling edge; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mdl_cnt = 0;
            prev_x  = -1;
        end else begin
            cyc++;
            chk("cnt16", {16'h0, cnt16}, mdl_cnt & 32'hffff);
            chk("cnt4", {28'h0, cnt4}, mdl_cnt & 32'hf);
            if (!b2b) prev_x = -1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", {23'h0, out_last, out_byte}, 32'h1ff);
                end else begin
                    chk("out_byte_last", {23'h0, out_last, out_byte}, {23'h0, q[0]});
                    if (out_ready) begin
                        void'(q.pop_front());
                        mdl_cnt++;
                        if (b2b) begin
                            if (prev_x >= 0) chk("b2b_gap", cyc - prev_x, 2);
                            prev_x = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] n, input logic l);
        bit acc = 0;
        int t = 0;
        in_valid  = 1'b1;
        in_nibble = n;
        in_last   = l;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        else if (!have_lo) begin
            lo_m = n;
            if (l) q.push_back({1'b1, n, 4'h0});
            else   have_lo = 1;
        end else begin
            q.push_back({l, lo_m, n});
            have_lo = 0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        int t = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", q.size(), 0);
        idle(2);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_nibble = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_byte", {24'h0, out_byte}, 0);
        chk("rst_count", {16'h0, cnt16}, 0);
        chk("rst_error", {31'h0, err}, 0);
        chk("rst_in_ready", {31'h0, in_ready}, 1);
        @(posedge clk); #1; rst = 1'b0;
        idle(1);

        // Single pair C,8: visible the cycle after the hi nibble is accepted.
        send(4'hC, 1'b0);
        send(4'h8, 1'b1);
        chk("t1_valid", {31'h0, out_valid}, 1);
        chk("t1_byte_dec", {24'h0, out_byte}, 200);
        chk("t1_lo", {28'h0, out_byte[7:4]}, 4'hC);
        chk("t1_hi", {28'h0, out_byte[3:0]}, 4'h8);
        chk("t1_last", {31'h0, out_last}, 1);
        drain();
        chk("t1_count", {16'h0, cnt16}, 1);
        chk("t1_error", {31'h0, err}, 0);

        // Backpressure: byte 12 held while the hi nibble 4 waits.
        out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        in_nibble = 4'h4; in_last = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t2_hi_blocked", {31'h0, in_ready}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        send(4'h7, 1'b0);
        send(4'h8, 1'b1);
        drain();
        chk("t2_count", {16'h0, cnt16}, 5);

        // Odd packet gets padded and sets the sticky error.
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b1);
        drain();
        chk("t3_error", {31'h0, err}, 1);
        send(4'h1, 1'b0);
        send(4'h2, 1'b1);
        drain();
        chk("t3_error_sticky", {31'h0, err}, 1);

        // Mid-cycle reset with a byte pending and a lo nibble held.
        out_ready = 1'b0;
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        send(4'h5, 1'b0);
        in_valid = 1'b0;
        #2; rst = 1'b1; #1;
        chk("t4_rst_valid", {31'h0, out_valid}, 0);
        chk("t4_rst_count", {16'h0, cnt16}, 0);
        chk("t4_rst_error", {31'h0, err}, 0);
        have_lo = 0;
        @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
        send(4'h6, 1'b0);
        send(4'h7, 1'b1);
        drain();
        chk("t4_count", {16'h0, cnt16}, 1);

        // 16 more bytes: the 4-bit counter wraps through 15 -> 0 and lands on 1.
        for (int i = 0; i < 16; i++) begin
            send(i[3:0], 1'b0);
            send(~i[3:0], i == 15);
        end
        drain();
        chk("t5_cnt4_wrap", {28'h0, cnt4}, 1);
        chk("t5_cnt16", {16'h0, cnt16}, 17);

        // Back-to-back 6-nibble packet: one byte every 2 cycles.
        b2b = 1;
        for (int i = 0; i < 6; i++) send(4'(i + 3), i == 5);
        in_valid = 1'b0;
        drain();
        b2b = 0;
        chk("t6_count", {16'h0, cnt16}, 20);
        chk("t6_error", {31'h0, err}, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/nibble_pair_packer.md
Name: nibble_pair_packer

Overview:
- Upstream feeder for the packed unsigned byte struct {lo[3:0], hi[3:0]}.
- Collects a valid/ready stream of 4-bit nibbles and assembles pairs into 8-bit packed bytes in struct bit order: lo = out_byte[7:4], hi = out_byte[3:0].
- Pads odd-length packets, counts emitted bytes, and flags odd packets on a sticky ERROR.
- A single-entry output register decouples the upstream side from backpressure downstream.

Parameters:
- PAD_NIBBLE, 4'h0, value placed in the hi field when a packet ends on a lo nibble.
- COUNT_W, 16, width of byte_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  nibble present
- in_ready  output  1  block accepts nibble this cycle
- in_nibble  input  4  nibble data
- in_last  input  1  nibble is last of its packet
- out_valid  output  1  out_byte holds a byte
- out_ready  input  1  downstream accepts byte
- out_byte  output  8  packed unsigned {lo, hi}
- out_last  output  1  byte is last of its packet
- byte_count  output  COUNT_W  bytes handed off since reset
- ERROR  output  1  sticky: an odd-length packet was padded

Behaviour:
- Reset (async, immediate): state=LO_WAIT, lo_hold=0, out_valid=0, out_byte=0, out_last=0, byte_count=0, ERROR=0. Reset mid-packet discards held nibble and any pending byte. No output is produced from pre-reset data.
- slot_free = !out_valid || out_ready.
- Handshakes: input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready. Once out_valid is asserted, out_byte and out_last stay stable until the output transfer.
- State LO_WAIT:
  - in_ready=1.
  - On transfer: lo_hold<=in_nibble.
  - If in_last=0, next state is HI_WAIT; if in_last=1, next state is PAD.
- State HI_WAIT:
  - in_ready=slot_free.
  - On transfer: out_byte<={lo_hold, in_nibble}, out_valid<=1, out_last<=in_last, next state LO_WAIT.
- State PAD:
  - in_ready=0.
  - When slot_free: out_byte<={lo_hold, PAD_NIBBLE}, out_last<=1, out_valid<=1, ERROR<=1, next state LO_WAIT.
- Output register: on an output transfer with no new load in the same cycle, out_valid<=0. A load and a transfer in the same cycle leave out_valid=1 holding the new byte, giving full throughput.
- Latency: a byte is visible on out_valid the cycle after its hi nibble is accepted. A padded byte is visible the cycle after PAD is entered if the slot is free.
- Throughput: at most one byte per two input cycles, i.e. one nibble per cycle sustained.
- byte_count: increments by 1 on each output transfer. Wraps modulo 2^COUNT_W with no saturation.
- Width rule: out_byte is unsigned. Concatenation is zero-extended whenever compared with wider integers; for example {4'hC,4'h8} equals decimal 200.
- ERROR: set only in PAD and cleared only by rst. An even-length packet never sets it.
- in_last on an accepted hi nibble marks out_last on that byte. in_last on a lo nibble forces padding.
- Outputs are unaffected by in_* while in_valid=0.

Test Plan:
- Send nibbles 4'hC then 4'h8 (last on 8), out_ready=1 → one byte out_byte=8'hC8 (==200), out_byte[7:4]=4'hC, out_byte[3:0]=4'h8, out_last=1; byte_count=1; ERROR=0.
- Stream 8 nibbles 1..8 (last on 8) with out_ready held 0 for 5 cycles after first byte → out_byte=8'h12 held stable; in_ready=0 in HI_WAIT while blocked; bytes 12,34,56,78 in order with no loss; out_last only on 78; byte_count=4.
- Odd packet: nibbles A,B,C (last on C), PAD_NIBBLE=4'h0 → bytes 8'hAB then 8'hC0 with out_last=1; ERROR=1 and stays 1 through a following even packet.
- COUNT_W=4: pass 17 bytes → byte_count reads 1 after wrap, with no glitch at the 15→0 transition.
- Assert rst asynchronously (mid-cycle) after lo nibble 4'h5 accepted and with one byte pending unacked → out_valid, byte_count, ERROR drop to 0 immediately. After release, sending 4'h6,4'h7 yields 8'h67 (not 8'h56).
- Back-to-back: out_ready=1, in_valid=1 continuously for a 6-nibble packet → a new byte every 2 cycles, out_valid never drops between bytes that are ready.
